// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with program-loadable imem and IF/ID register
//
// Purpose: holds the fetch PC, reads a word-addressed instruction memory
// combinationally at the PC and registers the result into the IF/ID stage.
// The PC can be held (stall_i) or redirected (redirect_i); any redirect,
// misaligned target or out-of-range fetch produces a bubble (NOP_WORD,
// valid_o=0). Misaligned targets and out-of-range fetches also latch
// fault_o until reset.
//
// Ports:
//   clk            single clock, rising edge
//   rst            synchronous active-low reset
//   stall_i        hold PC and IF/ID register
//   redirect_i     load redirect_pc_i into PC and flush IF/ID (beats stall_i)
//   redirect_pc_i  redirect byte address (low two bits truncated)
//   prog_we_i      instruction memory write enable
//   prog_addr_i    word index for program load
//   prog_data_i    word to write
//   pc_o           current fetch PC
//   inst_o         registered instruction (IF/ID)
//   pc_p4_o        registered PC+4 of inst_o
//   valid_o        inst_o is a real fetched instruction
//   fault_o        sticky fetch fault

module fetch_stage #(
  parameter int unsigned IMEM_DEPTH = 32,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          stall_i,
  input  logic                          redirect_i,
  input  logic [31:0]                   redirect_pc_i,
  input  logic                          prog_we_i,
  input  logic [$clog2(IMEM_DEPTH)-1:0] prog_addr_i,
  input  logic [31:0]                   prog_data_i,
  output logic [31:0]                   pc_o,
  output logic [31:0]                   inst_o,
  output logic [31:0]                   pc_p4_o,
  output logic                          valid_o,
  output logic                          fault_o
);

  localparam int unsigned AW = $clog2(IMEM_DEPTH);

  // Contents start as NOP_WORD at power-up; reset deliberately leaves them alone
  // so a program loaded while rst is low survives the reset release.
  logic [31:0] imem_q [IMEM_DEPTH] = '{default: NOP_WORD};

  logic [31:0]   pc_q, pc_d;
  logic [31:0]   inst_q, inst_d;
  logic [31:0]   pc_p4_q, pc_p4_d;
  logic          valid_q, valid_d;
  logic          fault_q, fault_d;

  logic [AW-1:0] fetch_idx;
  logic          fetch_in_range;
  logic [31:0]   fetch_word;
  logic [31:0]   pc_plus4;

  // Word index is pc[31:2]; anything above the low AW index bits set means
  // the index is >= IMEM_DEPTH.
  assign fetch_idx      = pc_q[AW+1:2];
  assign fetch_in_range = (pc_q[31:AW+2] == '0);
  // Asynchronous read: a write to the same index this cycle is not yet visible,
  // so the fetch sees the old word.
  assign fetch_word     = imem_q[fetch_idx];
  assign pc_plus4       = pc_q + 32'd4;

  always_comb begin
    pc_d    = pc_q;
    inst_d  = inst_q;
    pc_p4_d = pc_p4_q;
    valid_d = valid_q;
    fault_d = fault_q;
    if (redirect_i) begin
      pc_d    = {redirect_pc_i[31:2], 2'b00};
      inst_d  = NOP_WORD;
      pc_p4_d = 32'd0;
      valid_d = 1'b0;
      if (redirect_pc_i[1:0] != 2'b00) begin
        fault_d = 1'b1;
      end
    end else if (!stall_i) begin
      pc_d    = pc_plus4;
      pc_p4_d = pc_plus4;
      if (fetch_in_range) begin
        inst_d  = fetch_word;
        valid_d = 1'b1;
      end else begin
        // The PC keeps advancing past the end of memory; each such fetch is a bubble.
        inst_d  = NOP_WORD;
        valid_d = 1'b0;
        fault_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q    <= RESET_PC;
      inst_q  <= NOP_WORD;
      pc_p4_q <= 32'd0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      pc_p4_q <= pc_p4_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
    end
  end

  // Program writes are accepted regardless of reset, stall or redirect.
  always_ff @(posedge clk) begin
    if (prog_we_i) begin
      imem_q[prog_addr_i] <= prog_data_i;
    end
  end

  assign pc_o    = pc_q;
  assign inst_o  = inst_q;
  assign pc_p4_o = pc_p4_q;
  assign valid_o = valid_q;
  assign fault_o = fault_q;

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter IMEM_DEPTH, default 32, instruction memory depth in 32-bit words (power of two, 4..1024).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset (word aligned).
REQ-003 SHALL have parameter NOP_WORD, default 32'h0000_0000, instruction injected on flush, stall-free bubble or fault.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port stall_i  input  1  hold PC and IF/ID register.
REQ-007 SHALL have port redirect_i  input  1  branch/jump taken; load redirect_pc_i, flush IF/ID.
REQ-008 SHALL have port redirect_pc_i  input  32  redirect target byte address.
REQ-009 SHALL have port prog_we_i  input  1  instruction memory write enable.
REQ-010 SHALL have port prog_addr_i  input  $clog2(IMEM_DEPTH)  word index for program load.
REQ-011 SHALL have port prog_data_i  input  32  word to write.
REQ-012 SHALL have port pc_o  output  32  current fetch PC.
REQ-013 SHALL have port inst_o  output  32  registered instruction (IF/ID).
REQ-014 SHALL have port pc_p4_o  output  32  registered PC+4 of inst_o.
REQ-015 SHALL have port valid_o  output  1  inst_o is a real fetched instruction, not a bubble.
REQ-016 SHALL have port fault_o  output  1  sticky fetch fault (out-of-range or misaligned).

Function
REQ-017 SHALL read instruction memory combinationally at index pc_o[31:2]; index >= IMEM_DEPTH is out of range.
REQ-018 SHALL, when no stall/redirect, update per cycle: pc_o <= pc_o+4 (mod 2^32, FFFF_FFFC wraps to 0); inst_o <= imem word; pc_p4_o <= pc_o+4; valid_o <= 1.
REQ-019 SHALL, on stall_i=1 and redirect_i=0, hold pc_o, inst_o, pc_p4_o, valid_o unchanged.
REQ-020 SHALL give redirect_i priority over stall_i: pc_o <= {redirect_pc_i[31:2],2'b00}; inst_o <= NOP_WORD; pc_p4_o <= 0; valid_o <= 0 (one-cycle bubble).
REQ-021 SHALL set fault_o when redirect_pc_i[1:0] != 0 with redirect_i=1; target still truncated per REQ-020.
REQ-022 SHALL, on out-of-range fetch without stall/redirect, load inst_o <= NOP_WORD, valid_o <= 0, pc_p4_o <= pc_o+4, set fault_o, and still advance pc_o.
REQ-023 SHALL keep fault_o set until reset.
REQ-024 SHALL write prog_data_i to imem[prog_addr_i] on rising edge when prog_we_i=1, independent of stall/redirect.
REQ-025 SHALL return the old word when fetch index equals prog_addr_i in the write cycle; new word visible next cycle.
REQ-026 SHALL exhibit one-cycle fetch-to-inst_o latency; redirect target instruction appears on inst_o two edges after redirect_i sampled.
REQ-027 SHALL initialise imem contents to NOP_WORD at time zero; reset does not clear imem.

Reset
REQ-028 SHALL, on rising edge with rst=0, set pc_o=RESET_PC, inst_o=NOP_WORD, pc_p4_o=0, valid_o=0, fault_o=0.
REQ-029 SHALL give reset priority over redirect_i, stall_i and fault set; prog_we_i writes still occur during reset.
REQ-030 SHALL, on reset mid-stall or mid-redirect, discard pending state; first fetch after release is at RESET_PC.

Verification
REQ-031 SHALL cover sequential fetch: load imem[0..3]=200A0005,AC0A0014,8C0B0014,014B6020, release rst -> inst_o in order over 4 cycles, pc_p4_o=4,8,12,16, valid_o=1.
REQ-032 SHALL cover stall: stall_i=1 for 3 cycles at pc_o=8 -> pc_o=8, inst_o=AC0A0014 held; resume -> 8C0B0014.
REQ-033 SHALL cover redirect+stall same cycle: redirect_pc_i=0x10 -> next cycle pc_o=0x10, valid_o=0, inst_o=0; following cycle inst_o=imem[4].
REQ-034 SHALL cover misaligned redirect 0x0000_0006 -> pc_o=4, fault_o=1, stays 1 until rst=0.
REQ-035 SHALL cover out-of-range: IMEM_DEPTH=32, pc_o reaches 0x80 -> valid_o=0, inst_o=NOP_WORD, fault_o=1, pc_o=0x84 next.
REQ-036 SHALL cover write/read collision: prog_we_i at index 2 while fetching pc_o=8 -> inst_o old word; refetch after redirect to 8 -> new word.
